// File: rtl/phase_inc_calibrator_if.sv
// Handshake/bus bundle for phase_inc_calibrator.
// master: drives start, refTick, phaseInc and observes the result outputs.
// slave: the calibrator; receives requests and ticks and drives the results.
interface phase_inc_calibrator_if;
    logic        start;
    logic        refTick;
    logic [31:0] phaseInc;
    logic [31:0] phaseIncCorr;
    logic [31:0] measCount;
    logic        valid;
    logic        busy;
    logic        sat;
    logic        error;

    modport master (
        output start, refTick, phaseInc,
        input  phaseIncCorr, measCount, valid, busy, sat, error
    );

    modport slave (
        input  start, refTick, phaseInc,
        output phaseIncCorr, measCount, valid, busy, sat, error
    );
endinterface

// File: rtl/phase_inc_calibrator.sv
// Measures CLK cycles over a refTick gate and corrects an NCO phase increment:
// phaseIncCorr = floor(phaseInc * EXPECTED_COUNT / M), saturated to 32 bits.
// Ports: CLK, RST (async, active high); bus (slave): start, refTick, phaseInc in;
// phaseIncCorr, measCount, valid, busy, sat, error out (all registered).
module phase_inc_calibrator #(
    parameter int unsigned GATE_TICKS     = 1,
    parameter logic [31:0] EXPECTED_COUNT = 32'd50000000,
    parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
    input logic                   CLK,
    input logic                   RST,
    phase_inc_calibrator_if.slave bus
);

    localparam logic [31:0] GATE_LIM = 32'(GATE_TICKS);
    localparam logic [31:0] TIME_LIM = 32'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {IDLE, ARM, COUNT, MULT, DIV, DONE} state_t;

    state_t      state;
    state_t      stateNext;
    logic [31:0] incLatched;
    logic [31:0] mCount;
    logic [31:0] tickCnt;
    logic [31:0] idleCnt;
    logic [63:0] quot;
    logic [31:0] rem;
    logic [5:0]  stepCnt;

    logic        accept;
    logic        timeout;
    logic        gateClose;
    logic        mOverflow;
    logic        errSet;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        trialFits;
    logic        unusedTop;

    // busy stays high through the valid cycle, so a new start is only taken
    // once the result pulse has dropped.
    assign accept    = (state == IDLE) && bus.start && !bus.busy;
    assign timeout   = (idleCnt + 32'd1) >= TIME_LIM;
    assign gateClose = bus.refTick && ((tickCnt + 32'd1) == GATE_LIM);
    assign mOverflow = (mCount == 32'hFFFF_FFFE);

    // Restoring divide step: the remainder is always below M, so bit 32 of
    // whichever candidate is kept is zero.
    assign shifted   = {rem, quot[63]};
    assign trialFits = shifted >= {1'b0, mCount};
    assign diff      = shifted - {1'b0, mCount};
    assign unusedTop = diff[32] | shifted[32];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        errSet    = 1'b0;
        unique case (state)
            IDLE:  if (accept) stateNext = ARM;
            ARM: begin
                if (bus.refTick) begin
                    stateNext = COUNT;
                end else if (timeout) begin
                    stateNext = IDLE;
                    errSet    = 1'b1;
                end
            end
            COUNT: begin
                if (mOverflow || (!bus.refTick && timeout)) begin
                    stateNext = IDLE;
                    errSet    = 1'b1;
                end else if (gateClose) begin
                    stateNext = MULT;
                end
            end
            MULT:  stateNext = DIV;
            DIV:   if (stepCnt == 6'd63) stateNext = DONE;
            DONE:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            incLatched       <= '0;
            mCount           <= '0;
            tickCnt          <= '0;
            idleCnt          <= '0;
            quot             <= '0;
            rem              <= '0;
            stepCnt          <= '0;
            bus.phaseIncCorr <= '0;
            bus.measCount    <= '0;
            bus.valid        <= 1'b0;
            bus.busy         <= 1'b0;
            bus.sat          <= 1'b0;
            bus.error        <= 1'b0;
        end else begin
            bus.valid <= 1'b0;
            bus.busy  <= (stateNext != IDLE) || (state == DONE);
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        incLatched <= bus.phaseInc;
                        idleCnt    <= '0;
                        bus.error  <= 1'b0;
                    end
                end
                ARM: begin
                    if (bus.refTick) begin
                        mCount  <= '0;
                        tickCnt <= '0;
                        idleCnt <= '0;
                    end else begin
                        idleCnt <= idleCnt + 32'd1;
                    end
                end
                COUNT: begin
                    mCount <= mCount + 32'd1;
                    if (bus.refTick) begin
                        tickCnt <= tickCnt + 32'd1;
                        idleCnt <= '0;
                    end else begin
                        idleCnt <= idleCnt + 32'd1;
                    end
                end
                MULT: begin
                    quot    <= 64'(incLatched) * 64'(EXPECTED_COUNT);
                    rem     <= '0;
                    stepCnt <= '0;
                end
                DIV: begin
                    quot    <= {quot[62:0], trialFits};
                    rem     <= trialFits ? diff[31:0] : shifted[31:0];
                    stepCnt <= stepCnt + 6'd1;
                end
                DONE: begin
                    bus.measCount <= mCount;
                    bus.valid     <= 1'b1;
                    if (quot[63:32] != 32'd0) begin
                        bus.phaseIncCorr <= 32'hFFFF_FFFF;
                        bus.sat          <= 1'b1;
                    end else begin
                        bus.phaseIncCorr <= quot[31:0];
                        bus.sat          <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (errSet) bus.error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_phase_inc_calibrator.sv
// Self-checking bench for phase_inc_calibrator (GATE_TICKS=4,
// EXPECTED_COUNT=400, TIMEOUT_CYCLES=1000) using an expected-result queue.
`timescale 1ns/1ps
module tb_phase_inc_calibrator;

    localparam int GT = 4;
    localparam int TO = 1000;

    typedef struct {
        logic [31:0] corr;
        logic [31:0] meas;
        logic        sat;
    } res_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   edgeNo = 0;
    int   checks = 0;
    int   failures = 0;
    res_t sbq[$];
    logic [31:0] holdCorr = '0;
    logic [31:0] holdMeas = '0;
    logic        holdSat = 1'b0;

    phase_inc_calibrator_if bus();

    phase_inc_calibrator #(
        .GATE_TICKS(GT),
        .EXPECTED_COUNT(32'd400),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) edgeNo <= edgeNo + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        repeat (3) @(negedge CLK);
        checks++;
        if ({bus.phaseIncCorr, bus.measCount, bus.valid, bus.busy, bus.sat, bus.error} !== 68'd0) begin
            failures++;
            $display("FAIL reset_hold: corr=%h meas=%h v=%b b=%b s=%b e=%b required all 0",
                bus.phaseIncCorr, bus.measCount, bus.valid, bus.busy, bus.sat, bus.error);
        end
        RST = 1'b0;
        @(posedge CLK); #1;
        checks++;
        if ({bus.phaseIncCorr, bus.measCount, bus.valid, bus.busy, bus.sat, bus.error} !== 68'd0) begin
            failures++;
            $display("FAIL reset_release: corr=%h meas=%h v=%b b=%b s=%b e=%b required all 0",
                bus.phaseIncCorr, bus.measCount, bus.valid, bus.busy, bus.sat, bus.error);
        end
    endtask

    // One gate: opening tick plus GT ticks spaced 'period' apart.
    task automatic measure(input int period, input logic [31:0] pi,
                           input logic [31:0] eCorr, input logic [31:0] eMeas,
                           input logic eSat, input bit pokeStart, input bit abortDiv);
        res_t e;
        res_t got;
        int   ticks;
        int   k;
        int   closeEdge;
        int   budget;
        bit   seen;
        bit   aborted;
        bit   lateValid;
        e.corr = eCorr;
        e.meas = eMeas;
        e.sat  = eSat;
        sbq.push_back(e);
        @(negedge CLK);
        bus.start    = 1'b1;
        bus.phaseInc = pi;
        @(posedge CLK); #1;
        checks++;
        if (bus.busy !== 1'b1 || bus.error !== 1'b0) begin
            failures++;
            $display("FAIL accept: busy=%b error=%b required busy=1 error=0", bus.busy, bus.error);
        end
        ticks = 0;
        k = 0;
        closeEdge = 0;
        seen = 0;
        aborted = 0;
        budget = period * GT + 200;
        while (!seen && !aborted && k < budget) begin
            @(negedge CLK);
            bus.start = 1'b0;
            if (k == 0) bus.phaseInc = ~pi;
            bus.refTick = (ticks <= GT) && (k % period == 1);
            if (bus.refTick) begin
                ticks++;
                if (ticks == GT + 1) closeEdge = edgeNo + 1;
            end
            if (pokeStart && ticks == 2 && (k % period) == period / 2) begin
                bus.start    = 1'b1;
                bus.phaseInc = 32'h0000_1234;
            end
            @(posedge CLK); #1;
            if (bus.valid === 1'b1) seen = 1;
            if (abortDiv && ticks > GT && edgeNo == closeEdge + 30) aborted = 1;
            k++;
        end
        bus.refTick = 1'b0;
        bus.start   = 1'b0;
        if (aborted) begin
            #2;
            RST = 1'b1;
            #1;
            checks++;
            if ({bus.phaseIncCorr, bus.measCount, bus.valid, bus.busy, bus.sat, bus.error} !== 68'd0) begin
                failures++;
                $display("FAIL async_reset: corr=%h meas=%h v=%b b=%b s=%b e=%b required all 0",
                    bus.phaseIncCorr, bus.measCount, bus.valid, bus.busy, bus.sat, bus.error);
            end
            void'(sbq.pop_back());
            holdCorr = '0;
            holdMeas = '0;
            holdSat  = 1'b0;
            @(negedge CLK);
            @(negedge CLK);
            RST = 1'b0;
            lateValid = 0;
            for (int i = 0; i < 100; i++) begin
                @(posedge CLK); #1;
                if (bus.valid !== 1'b0 || bus.busy !== 1'b0) lateValid = 1;
            end
            checks++;
            if (lateValid) begin
                failures++;
                $display("FAIL post_reset_quiet: valid/busy seen=1 required 0");
            end
            return;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL valid_timeout: no valid within %0d cycles required one", budget);
            void'(sbq.pop_front());
            return;
        end
        got.corr = bus.phaseIncCorr;
        got.meas = bus.measCount;
        got.sat  = bus.sat;
        e = sbq.pop_front();
        holdCorr = e.corr;
        holdMeas = e.meas;
        holdSat  = e.sat;
        checks++;
        if (got.corr !== e.corr) begin
            failures++;
            $display("FAIL corr: got %0d required %0d", got.corr, e.corr);
        end
        checks++;
        if (got.meas !== e.meas) begin
            failures++;
            $display("FAIL measCount: got %0d required %0d", got.meas, e.meas);
        end
        checks++;
        if (got.sat !== e.sat) begin
            failures++;
            $display("FAIL sat: got %b required %b", got.sat, e.sat);
        end
        checks++;
        if (edgeNo - closeEdge != 66) begin
            failures++;
            $display("FAIL latency: got %0d edges required 66", edgeNo - closeEdge);
        end
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_at_valid: got %b required 1", bus.busy);
        end
        @(posedge CLK); #1;
        checks++;
        if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL after_valid: valid=%b busy=%b required 0 0", bus.valid, bus.busy);
        end
    endtask

    task automatic test_timeout;
        int n;
        bit sawValid;
        @(negedge CLK);
        bus.start    = 1'b1;
        bus.phaseInc = 32'd1;
        @(posedge CLK); #1;
        @(negedge CLK);
        bus.start = 1'b0;
        n = 0;
        sawValid = 0;
        while (bus.busy === 1'b1 && n < 1200) begin
            @(posedge CLK); #1;
            n++;
            if (bus.valid === 1'b1) sawValid = 1;
        end
        checks++;
        if (n != TO) begin
            failures++;
            $display("FAIL timeout_cycles: busy fell after %0d edges required %0d", n, TO);
        end
        checks++;
        if (bus.error !== 1'b1) begin
            failures++;
            $display("FAIL timeout_error: got %b required 1", bus.error);
        end
        checks++;
        if (sawValid) begin
            failures++;
            $display("FAIL timeout_valid: valid pulse seen required none");
        end
        checks++;
        if (bus.phaseIncCorr !== holdCorr || bus.measCount !== holdMeas || bus.sat !== holdSat) begin
            failures++;
            $display("FAIL timeout_hold: corr=%h meas=%0d sat=%b required %h %0d %b",
                bus.phaseIncCorr, bus.measCount, bus.sat, holdCorr, holdMeas, holdSat);
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.refTick  = 1'b0;
        bus.phaseInc = '0;
        test_reset();
        measure(100, 32'd858993459, 32'd858993459, 32'd400, 1'b0, 0, 0);
        measure(101, 32'd858993459, 32'd850488573, 32'd404, 1'b0, 0, 0);
        measure(99,  32'd858993459, 32'd867670160, 32'd396, 1'b0, 0, 0);
        measure(50,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd200, 1'b1, 0, 0);
        test_timeout();
        measure(100, 32'd858993459, 32'd858993459, 32'd400, 1'b0, 0, 0);
        measure(101, 32'd858993459, 32'd850488573, 32'd404, 1'b0, 0, 1);
        measure(101, 32'd858993459, 32'd850488573, 32'd404, 1'b0, 1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
